// File: rtl/psram_qpi_pkg.sv
// Shared command codes and FSM state encoding for the QSPI/QPI PSRAM device model.
package psram_qpi_pkg;

  localparam logic [7:0] CMD_READ   = 8'hEB;
  localparam logic [7:0] CMD_WRITE  = 8'h38;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/psram_sync_edge.sv
// Brings sck, ce_n and dio into the clock domain and produces single-cycle
// sck rise/fall and ce_n rise pulses from the synchronized levels.
module psram_sync_edge (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck_i,
  input  logic       ce_n_i,
  input  logic [3:0] dio_i,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ce_n_o,
  output logic       ce_rise_o,
  output logic [3:0] dio_o
);

  logic       sck_q1, sck_q2, sck_q3;
  logic       ce_q1, ce_q2, ce_q3;
  logic [3:0] dio_q1, dio_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_q1 <= 1'b0;
      sck_q2 <= 1'b0;
      sck_q3 <= 1'b0;
      ce_q1  <= 1'b1;
      ce_q2  <= 1'b1;
      ce_q3  <= 1'b1;
      dio_q1 <= 4'h0;
      dio_q2 <= 4'h0;
    end else begin
      sck_q1 <= sck_i;
      sck_q2 <= sck_q1;
      sck_q3 <= sck_q2;
      ce_q1  <= ce_n_i;
      ce_q2  <= ce_q1;
      ce_q3  <= ce_q2;
      dio_q1 <= dio_i;
      dio_q2 <= dio_q1;
    end
  end

  // q3 is the previous synchronized level, used only for edge detection
  assign sck_rise_o = sck_q2 & ~sck_q3;
  assign sck_fall_o = ~sck_q2 & sck_q3;
  assign ce_rise_o  = ce_q2 & ~ce_q3;
  assign ce_n_o     = ce_q2;
  assign dio_o      = dio_q2;

endmodule

// File: rtl/psram_qpi_dev.sv
// Behavioural PSRAM device: SPI/QPI command decode, quad address/data phases
// and an inferred byte array, all clocked from the system clock.
module psram_qpi_dev
  import psram_qpi_pkg::*;
#(
  parameter int MEM_AW       = 16,
  parameter int READ_LATENCY = 6,
  parameter bit RESET_QPI    = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic       dio_oe,
  output logic       qpi_mode
);

  logic              sck_rise, sck_fall, ce_n_s, ce_rise;
  logic [3:0]        dio_s;
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cmd_q, cmd_d, cmd_nx;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              nib_q, nib_d, wr_q, wr_d, oe_q, oe_d, qpi_q, qpi_d;
  logic              armed_q, armed_d;
  logic [1:0]        settle_q, settle_d;
  logic [3:0]        wbuf_q, wbuf_d, dout_q, dout_d;
  logic [7:0]        wbyte_q, wbyte_d, rd_byte;
  logic [7:0]        mem_q [2**MEM_AW];

  psram_sync_edge u_sync (
    .clock      (clock),
    .reset      (reset),
    .sck_i      (sck),
    .ce_n_i     (ce_n),
    .dio_i      (dio_i),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .ce_n_o     (ce_n_s),
    .ce_rise_o  (ce_rise),
    .dio_o      (dio_s)
  );

  assign rd_byte = mem_q[addr_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      cmd_q    <= 8'd0;
      addr_q   <= '0;
      nib_q    <= 1'b0;
      wr_q     <= 1'b0;
      oe_q     <= 1'b0;
      dout_q   <= 4'h0;
      qpi_q    <= RESET_QPI;
      armed_q  <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      nib_q    <= nib_d;
      wr_q     <= wr_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
      qpi_q    <= qpi_d;
      armed_q  <= armed_d;
      settle_q <= settle_d;
    end
    wbuf_q  <= wbuf_d;
    wbyte_q <= wbyte_d;
  end

  // Only whole bytes are ever committed; reset suppresses a pending write
  always_ff @(posedge clock) begin
    if (wr_q && !reset) mem_q[addr_q] <= wbyte_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    cmd_nx   = cmd_q;
    addr_d   = addr_q;
    nib_d    = nib_q;
    wr_d     = 1'b0;
    oe_d     = oe_q;
    dout_d   = dout_q;
    qpi_d    = qpi_q;
    wbuf_d   = wbuf_q;
    wbyte_d  = wbyte_q;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    // A transaction may only start once ce_n has been seen high after reset
    armed_d  = armed_q | ((settle_q == 2'd3) & ce_n_s);

    if (wr_q) addr_d = addr_q + MEM_AW'(1);

    case (state_q)
      ST_IDLE: begin
        oe_d = 1'b0;
        if (armed_q && !ce_n_s) begin
          state_d = ST_CMD;
          cnt_d   = 8'd0;
        end
      end
      ST_CMD: if (sck_rise) begin
        cmd_nx = qpi_q ? {cmd_q[3:0], dio_s} : {cmd_q[6:0], dio_s[0]};
        cmd_d  = cmd_nx;
        cnt_d  = cnt_q + 8'd1;
        if ((qpi_q && cnt_q == 8'd1) || (!qpi_q && cnt_q == 8'd7)) begin
          cnt_d = 8'd0;
          case (cmd_nx)
            CMD_READ, CMD_WRITE: state_d = ST_ADDR;
            CMD_QPI_EN: begin qpi_d = 1'b1; state_d = ST_IGNORE; end
            CMD_QPI_EX: begin qpi_d = 1'b0; state_d = ST_IGNORE; end
            default:    state_d = ST_IGNORE;
          endcase
        end
      end
      ST_ADDR: if (sck_rise) begin
        addr_d = {addr_q[MEM_AW-5:0], dio_s};
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'd5) begin
          cnt_d = 8'd0;
          if (cmd_q == CMD_READ) state_d = (READ_LATENCY == 0) ? ST_RDATA : ST_WAIT;
          else                   state_d = ST_WDATA;
        end
      end
      ST_WAIT: if (sck_rise) begin
        cnt_d = cnt_q + 8'd1;
        if (int'(cnt_q) == READ_LATENCY - 1) begin
          cnt_d   = 8'd0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: if (sck_fall) begin
        oe_d   = 1'b1;
        dout_d = nib_q ? rd_byte[3:0] : rd_byte[7:4];
        nib_d  = ~nib_q;
        if (nib_q) addr_d = addr_q + MEM_AW'(1);
      end
      ST_WDATA: if (sck_rise) begin
        if (!nib_q) begin
          wbuf_d = dio_s;
          nib_d  = 1'b1;
        end else begin
          wbyte_d = {wbuf_q, dio_s};
          wr_d    = 1'b1;
          nib_d   = 1'b0;
        end
      end
      ST_IGNORE: oe_d = 1'b0;
      default:   state_d = ST_IDLE;
    endcase

    // End of transaction wins over any coincident sck edge
    if (ce_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      cnt_d   = 8'd0;
      nib_d   = 1'b0;
      addr_d  = '0;
      wr_d    = 1'b0;
    end
  end

  assign dio_o    = dout_q;
  assign dio_oe   = oe_q;
  assign qpi_mode = qpi_q;

endmodule
